pito_mvu_csr_resp: RTL and testbench

- MVU-side responder for the MVU CSR window (12'hF20–12'hF38) driven by the pito core's CSR unit.
- Decodes CSR ops (write/read/set/clear) and holds the MVU job configuration.
- A write to CSR_MVU_COMMAND launches the MVU through a start/done handshake.
- Raises the MVU interrupt (MIP_MVIP, IRQ_MVU_INTR=16) on job completion; one instance per MVU, between core CSR file and MVU datapath.

---
 rtl/pito_mvu_csr_resp_pkg.sv | 96 +++++++++
 rtl/pito_mvu_csr_resp_if.sv | 31 +++
 rtl/pito_mvu_csr_resp_alu.sv | 23 ++
 rtl/pito_mvu_csr_resp.sv | 168 ++++++++++++++++
 tb/tb_pito_mvu_csr_resp.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pito_mvu_csr_resp_pkg.sv
// Shared types and constants for the MVU CSR responder: CSR addresses, ops, config layout, FSM states.
package pito_mvu_csr_resp_pkg;

    localparam int PITO_XLEN    = 32;
    localparam int IRQ_MVU_INTR = 16;
    localparam int MVU_NUM_CFG  = 23;

    typedef logic [11:0] csr_t;

    typedef enum logic [2:0] {
        CSR_MRET  = 3'd0,
        CSR_WRITE = 3'd1,
        CSR_READ  = 3'd2,
        CSR_SET   = 3'd3,
        CSR_CLEAR = 3'd4
    } csr_op_t;

    localparam csr_t CSR_MVU_WBASEPTR  = 12'hF20;
    localparam csr_t CSR_MVU_IBASEPTR  = 12'hF21;
    localparam csr_t CSR_MVU_OBASEPTR  = 12'hF22;
    localparam csr_t CSR_MVU_WSTRIDE_0 = 12'hF23;
    localparam csr_t CSR_MVU_WSTRIDE_1 = 12'hF24;
    localparam csr_t CSR_MVU_WSTRIDE_2 = 12'hF25;
    localparam csr_t CSR_MVU_ISTRIDE_0 = 12'hF26;
    localparam csr_t CSR_MVU_ISTRIDE_1 = 12'hF27;
    localparam csr_t CSR_MVU_ISTRIDE_2 = 12'hF28;
    localparam csr_t CSR_MVU_OSTRIDE_0 = 12'hF29;
    localparam csr_t CSR_MVU_OSTRIDE_1 = 12'hF2A;
    localparam csr_t CSR_MVU_OSTRIDE_2 = 12'hF2B;
    localparam csr_t CSR_MVU_WLENGTH_0 = 12'hF2C;
    localparam csr_t CSR_MVU_WLENGTH_1 = 12'hF2D;
    localparam csr_t CSR_MVU_WLENGTH_2 = 12'hF2E;
    localparam csr_t CSR_MVU_ILENGTH_0 = 12'hF2F;
    localparam csr_t CSR_MVU_ILENGTH_1 = 12'hF30;
    localparam csr_t CSR_MVU_ILENGTH_2 = 12'hF31;
    localparam csr_t CSR_MVU_OLENGTH_0 = 12'hF32;
    localparam csr_t CSR_MVU_OLENGTH_1 = 12'hF33;
    localparam csr_t CSR_MVU_OLENGTH_2 = 12'hF34;
    localparam csr_t CSR_MVU_PRECISION = 12'hF35;
    localparam csr_t CSR_MVU_STATUS    = 12'hF36;
    localparam csr_t CSR_MVU_COMMAND   = 12'hF37;
    localparam csr_t CSR_MVU_QUANT     = 12'hF38;

    localparam csr_t MVU_CSR_LO = 12'hF20;
    localparam csr_t MVU_CSR_HI = 12'hF38;

    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;
    localparam int STATUS_DROP_BIT = 2;

    localparam logic [4:0] MVU_CFG_NONE = 5'd31;

    typedef struct packed {
        logic [PITO_XLEN-1:0] wbaseptr;
        logic [PITO_XLEN-1:0] ibaseptr;
        logic [PITO_XLEN-1:0] obaseptr;
        logic [PITO_XLEN-1:0] wstride_0;
        logic [PITO_XLEN-1:0] wstride_1;
        logic [PITO_XLEN-1:0] wstride_2;
        logic [PITO_XLEN-1:0] istride_0;
        logic [PITO_XLEN-1:0] istride_1;
        logic [PITO_XLEN-1:0] istride_2;
        logic [PITO_XLEN-1:0] ostride_0;
        logic [PITO_XLEN-1:0] ostride_1;
        logic [PITO_XLEN-1:0] ostride_2;
        logic [PITO_XLEN-1:0] wlength_0;
        logic [PITO_XLEN-1:0] wlength_1;
        logic [PITO_XLEN-1:0] wlength_2;
        logic [PITO_XLEN-1:0] ilength_0;
        logic [PITO_XLEN-1:0] ilength_1;
        logic [PITO_XLEN-1:0] ilength_2;
        logic [PITO_XLEN-1:0] olength_0;
        logic [PITO_XLEN-1:0] olength_1;
        logic [PITO_XLEN-1:0] olength_2;
        logic [PITO_XLEN-1:0] precision;
        logic [PITO_XLEN-1:0] quant;
    } mvu_cfg_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } mvu_fsm_t;

    // Config slot of an address; STATUS/COMMAND sit between PRECISION and QUANT.
    function automatic logic [4:0] mvu_cfg_index(csr_t a);
        if (a >= CSR_MVU_WBASEPTR && a <= CSR_MVU_PRECISION) begin
            return 5'(a - CSR_MVU_WBASEPTR);
        end
        if (a == CSR_MVU_QUANT) begin
            return 5'(MVU_NUM_CFG - 1);
        end
        return MVU_CFG_NONE;
    endfunction

endpackage

// File: rtl/pito_mvu_csr_resp_if.sv
// Core-CSR / MVU bundle seen by the MVU CSR responder; master = core+MVU side, slave = responder.
interface pito_mvu_csr_resp_if #(
    parameter int XLEN  = 32,
    parameter int CMD_W = 32
);
    import pito_mvu_csr_resp_pkg::*;

    logic                        csr_req_valid;
    csr_op_t                     csr_op;
    csr_t                        csr_addr;
    logic [XLEN-1:0]             csr_wdata;
    logic                        csr_hit;
    logic                        csr_rvalid;
    logic [XLEN-1:0]             csr_rdata;
    logic [MVU_NUM_CFG*XLEN-1:0] mvu_cfg;
    logic [CMD_W-1:0]            mvu_cmd;
    logic                        mvu_start;
    logic                        mvu_done;
    logic                        mvu_irq;

    modport master (
        output csr_req_valid, csr_op, csr_addr, csr_wdata, mvu_done,
        input  csr_hit, csr_rvalid, csr_rdata, mvu_cfg, mvu_cmd, mvu_start, mvu_irq
    );

    modport slave (
        input  csr_req_valid, csr_op, csr_addr, csr_wdata, mvu_done,
        output csr_hit, csr_rvalid, csr_rdata, mvu_cfg, mvu_cmd, mvu_start, mvu_irq
    );

endinterface

// File: rtl/pito_mvu_csr_resp_alu.sv
// CSR read-modify-write operator: produces the post-op value from the old value and operand.
module pito_mvu_csr_resp_alu
    import pito_mvu_csr_resp_pkg::*;
#(
    parameter int W = 32
) (
    input  csr_op_t        op_i,
    input  logic [W-1:0]   old_i,
    input  logic [W-1:0]   wdata_i,
    output logic [W-1:0]   new_o
);

    always_comb begin
        new_o = old_i;
        case (op_i)
            CSR_WRITE: new_o = wdata_i;
            CSR_SET:   new_o = old_i | wdata_i;
            CSR_CLEAR: new_o = old_i & ~wdata_i;
            default:   new_o = old_i;
        endcase
    end

endmodule

// File: rtl/pito_mvu_csr_resp.sv
// MVU-side CSR responder: config registers, command launch handshake, status and completion interrupt.
// Optional build macro PITO_MVU_CSR_SHADOW_EN drives mvu_cfg from a copy captured at job launch.
module pito_mvu_csr_resp
    import pito_mvu_csr_resp_pkg::*;
#(
    parameter int XLEN  = PITO_XLEN,
    parameter int CMD_W = 32
) (
    input  logic                pito_io_clk,
    input  logic                pito_io_rst_n,
    pito_mvu_csr_resp_if.slave  bus
);

    localparam int CFG_W = MVU_NUM_CFG * XLEN;

    logic            acc;
    logic            wr_op;
    logic            sts_wr;
    logic            cmd_wr;
    logic            cmd_accept;
    logic            job_done;
    logic [4:0]      cfg_idx;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] new_val;
    logic [XLEN-1:0] status_word;
    logic [CFG_W-1:0] cfg_live;

    mvu_fsm_t         state_q, state_d;
    logic             mvu_start;
    logic             done_pend_q, done_pend_d;
    logic             drop_q, drop_d;
    logic [CMD_W-1:0] mvu_cmd_q;
    logic             rvalid_q;
    logic [XLEN-1:0]  rdata_q;

    assign bus.csr_hit = (bus.csr_addr >= MVU_CSR_LO) && (bus.csr_addr <= MVU_CSR_HI);
    assign acc         = bus.csr_req_valid && bus.csr_hit;
    assign wr_op       = acc && (bus.csr_op == CSR_WRITE || bus.csr_op == CSR_SET ||
                                 bus.csr_op == CSR_CLEAR);
    assign sts_wr      = wr_op && (bus.csr_addr == CSR_MVU_STATUS);
    assign cmd_wr      = wr_op && (bus.csr_addr == CSR_MVU_COMMAND);
    assign cmd_accept  = cmd_wr && (state_q == IDLE);
    assign job_done    = (state_q == BUSY) && bus.mvu_done;
    assign cfg_idx     = mvu_cfg_index(bus.csr_addr);

    always_comb begin
        status_word                  = '0;
        status_word[STATUS_BUSY_BIT] = (state_q != IDLE);
        status_word[STATUS_DONE_BIT] = done_pend_q;
        status_word[STATUS_DROP_BIT] = drop_q;
    end

    always_comb begin
        old_val = '0;
        if (bus.csr_addr == CSR_MVU_STATUS) begin
            old_val = status_word;
        end else if (bus.csr_addr == CSR_MVU_COMMAND) begin
            old_val = XLEN'(mvu_cmd_q);
        end else if (cfg_idx != MVU_CFG_NONE) begin
            old_val = cfg_live[(MVU_NUM_CFG - 1 - int'(cfg_idx)) * XLEN +: XLEN];
        end
    end

    pito_mvu_csr_resp_alu #(.W(XLEN)) u_alu (
        .op_i    (bus.csr_op),
        .old_i   (old_val),
        .wdata_i (bus.csr_wdata),
        .new_o   (new_val)
    );

    // Slot 0 (WBASEPTR) lands in the MSBs so the flat bus matches mvu_cfg_t.
    for (genvar gi = 0; gi < MVU_NUM_CFG; gi++) begin : g_cfg
        logic [XLEN-1:0] reg_q;

        always_ff @(posedge pito_io_clk) begin
            if (!pito_io_rst_n) begin
                reg_q <= '0;
            end else if (wr_op && cfg_idx == 5'(gi)) begin
                reg_q <= new_val;
            end
        end

        assign cfg_live[(MVU_NUM_CFG - 1 - gi) * XLEN +: XLEN] = reg_q;
    end

    always_comb begin
        state_d   = state_q;
        mvu_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_accept) begin
                    state_d = START;
                end
            end
            START: begin
                mvu_start = 1'b1;
                state_d   = BUSY;
            end
            BUSY: begin
                if (bus.mvu_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Completion beats a same-cycle W1C so a finishing job is never lost.
    always_comb begin
        done_pend_d = done_pend_q;
        drop_d      = drop_q;
        if (job_done) begin
            done_pend_d = 1'b1;
        end else if (sts_wr && bus.csr_wdata[STATUS_DONE_BIT]) begin
            done_pend_d = 1'b0;
        end
        if (cmd_wr && state_q != IDLE) begin
            drop_d = 1'b1;
        end else if (sts_wr && bus.csr_wdata[STATUS_DROP_BIT]) begin
            drop_d = 1'b0;
        end
    end

    always_ff @(posedge pito_io_clk) begin
        if (!pito_io_rst_n) begin
            state_q     <= IDLE;
            done_pend_q <= 1'b0;
            drop_q      <= 1'b0;
            mvu_cmd_q   <= '0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            done_pend_q <= done_pend_d;
            drop_q      <= drop_d;
            rvalid_q    <= acc;
            if (cmd_accept) begin
                mvu_cmd_q <= CMD_W'(new_val);
            end
            if (acc) begin
                rdata_q <= (bus.csr_op == CSR_MRET) ? '0 : old_val;
            end
        end
    end

`ifdef PITO_MVU_CSR_SHADOW_EN
    logic [CFG_W-1:0] cfg_shadow_q;

    always_ff @(posedge pito_io_clk) begin
        if (!pito_io_rst_n) begin
            cfg_shadow_q <= '0;
        end else if (cmd_accept) begin
            cfg_shadow_q <= cfg_live;
        end
    end

    assign bus.mvu_cfg = cfg_shadow_q;
`else
    assign bus.mvu_cfg = cfg_live;
`endif

    assign bus.mvu_start  = mvu_start;
    assign bus.mvu_cmd    = mvu_cmd_q;
    assign bus.mvu_irq    = done_pend_q;
    assign bus.csr_rvalid = rvalid_q;
    assign bus.csr_rdata  = rdata_q;

endmodule

// File: tb/tb_pito_mvu_csr_resp.sv
// Bench for pito_mvu_csr_resp: directed table, hand sequences for handshake corners, randomized run vs a register model.
module tb_pito_mvu_csr_resp;
    import pito_mvu_csr_resp_pkg::*;

    localparam int XLEN  = 32;
    localparam int CMD_W = 32;
    localparam int NCFG  = MVU_NUM_CFG;
    localparam int CFGW  = NCFG * XLEN;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pito_mvu_csr_resp_if #(.XLEN(XLEN), .CMD_W(CMD_W)) bus ();

    pito_mvu_csr_resp #(.XLEN(XLEN), .CMD_W(CMD_W)) dut (
        .pito_io_clk   (clk),
        .pito_io_rst_n (rst_n),
        .bus           (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: register contents by address plus job bookkeeping by edge number.
    logic [XLEN-1:0]  m_reg [csr_t];
    logic [CMD_W-1:0] m_cmd;
    bit               m_active;
    int               m_launch;
    bit               m_pend;
    bit               m_drop;
    bit               m_started;
    logic [CFGW-1:0]  m_shadow;
    int               edge_n = 0;

    typedef struct {
        bit              v;
        csr_op_t         op;
        csr_t            addr;
        logic [31:0]     wd;
        bit              done;
        bit              exp_rv;
        logic [31:0]     exp_rd;
        bit              exp_start;
        bit              exp_irq;
    } vec_t;

    vec_t tbl [9];

    function automatic bit in_win(csr_t a);
        return a >= MVU_CSR_LO && a <= MVU_CSR_HI;
    endfunction

    function automatic bit is_cfg(csr_t a);
        return in_win(a) && a != CSR_MVU_STATUS && a != CSR_MVU_COMMAND;
    endfunction

    function automatic logic [CFGW-1:0] m_cfg_flat();
        logic [CFGW-1:0] f;
        int p;
        f = '0;
        p = 0;
        for (int a = int'(MVU_CSR_LO); a <= int'(MVU_CSR_HI); a++) begin
            if (is_cfg(csr_t'(a))) begin
                f[(NCFG - 1 - p) * XLEN +: XLEN] = m_reg[csr_t'(a)];
                p++;
            end
        end
        return f;
    endfunction

    task automatic m_reset();
        for (int a = int'(MVU_CSR_LO); a <= int'(MVU_CSR_HI); a++) begin
            m_reg[csr_t'(a)] = '0;
        end
        m_cmd     = '0;
        m_active  = 1'b0;
        m_launch  = 0;
        m_pend    = 1'b0;
        m_drop    = 1'b0;
        m_started = 1'b0;
        m_shadow  = '0;
    endtask

    task automatic chk(input string name, input logic [CFGW-1:0] act, input logic [CFGW-1:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.csr_req_valid = 1'b0;
        bus.csr_op        = CSR_READ;
        bus.csr_addr      = '0;
        bus.csr_wdata     = '0;
        bus.mvu_done      = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        drive_idle();
        rst_n = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_reset();
    endtask

    // One clock of stimulus; the model decides every expected output from pre-edge state.
    task automatic step(input bit v, input csr_op_t op, input csr_t addr,
                        input logic [31:0] wd, input bit done);
        logic [31:0] old;
        logic [31:0] nv;
        logic [31:0] exp_rd;
        bit          exp_hit;
        bit          exp_rv;
        bit          done_ok;
        bit          is_wr;
        logic [CFGW-1:0] exp_cfg;

        bus.csr_req_valid = v;
        bus.csr_op        = op;
        bus.csr_addr      = addr;
        bus.csr_wdata     = wd;
        bus.mvu_done      = done;
        #1;
        exp_hit = in_win(addr);
        chk("csr_hit", CFGW'(bus.csr_hit), CFGW'(exp_hit));

        exp_rv = v && exp_hit;
        old    = '0;
        if (addr == CSR_MVU_STATUS)       old = {29'b0, m_drop, m_pend, m_active};
        else if (addr == CSR_MVU_COMMAND) old = m_cmd;
        else if (is_cfg(addr))            old = m_reg[addr];
        exp_rd = (op == CSR_MRET) ? 32'h0 : old;
        case (op)
            CSR_WRITE: nv = wd;
            CSR_SET:   nv = old | wd;
            CSR_CLEAR: nv = old & ~wd;
            default:   nv = old;
        endcase
        is_wr     = exp_rv && (op == CSR_WRITE || op == CSR_SET || op == CSR_CLEAR);
        done_ok   = done && m_active && (edge_n >= m_launch + 2);
        m_started = 1'b0;
        if (is_wr) begin
            if (addr == CSR_MVU_COMMAND) begin
                if (!m_active) begin
                    m_cmd     = nv;
                    m_active  = 1'b1;
                    m_launch  = edge_n;
                    m_started = 1'b1;
                    m_shadow  = m_cfg_flat();
                end else begin
                    m_drop = 1'b1;
                end
            end else if (addr == CSR_MVU_STATUS) begin
                if (wd[1]) m_pend = 1'b0;
                if (wd[2]) m_drop = 1'b0;
            end else begin
                m_reg[addr] = nv;
            end
        end
        if (done_ok) begin
            m_pend   = 1'b1;
            m_active = 1'b0;
        end

        @(posedge clk);
        #1;
        edge_n++;
        vectors++;
`ifdef PITO_MVU_CSR_SHADOW_EN
        exp_cfg = m_shadow;
`else
        exp_cfg = m_cfg_flat();
`endif
        chk("rvalid", CFGW'(bus.csr_rvalid), CFGW'(exp_rv));
        if (exp_rv) chk("rdata", CFGW'(bus.csr_rdata), CFGW'(exp_rd));
        chk("mvu_start", CFGW'(bus.mvu_start), CFGW'(m_started));
        chk("mvu_irq", CFGW'(bus.mvu_irq), CFGW'(m_pend));
        chk("mvu_cmd", CFGW'(bus.mvu_cmd), CFGW'(m_cmd));
        chk("mvu_cfg", bus.mvu_cfg, exp_cfg);
    endtask

    task automatic idle_step(input bit done);
        step(1'b0, CSR_READ, 12'h000, 32'h0, done);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        mvu_cfg_t cfg_view;
        int       cd;
        bit       d;
        bit       v;
        csr_op_t  op;
        csr_t     addr;
        int       r;

        drive_idle();
        m_reset();
        do_reset(3);
        vectors++;
        chk("reset.rvalid", CFGW'(bus.csr_rvalid), '0);
        chk("reset.rdata",  CFGW'(bus.csr_rdata),  '0);
        chk("reset.start",  CFGW'(bus.mvu_start),  '0);
        chk("reset.irq",    CFGW'(bus.mvu_irq),    '0);
        chk("reset.cmd",    CFGW'(bus.mvu_cmd),    '0);
        chk("reset.cfg",    bus.mvu_cfg,           '0);

        tbl[0] = '{1'b1, CSR_READ,  CSR_MVU_WBASEPTR,  32'h0,  1'b0, 1'b1, 32'h0,  1'b0, 1'b0};
        tbl[1] = '{1'b1, CSR_WRITE, CSR_MVU_ISTRIDE_1, 32'hF0, 1'b0, 1'b1, 32'h0,  1'b0, 1'b0};
        tbl[2] = '{1'b1, CSR_SET,   CSR_MVU_ISTRIDE_1, 32'h0F, 1'b0, 1'b1, 32'hF0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, CSR_CLEAR, CSR_MVU_ISTRIDE_1, 32'h30, 1'b0, 1'b1, 32'hFF, 1'b0, 1'b0};
        tbl[4] = '{1'b1, CSR_READ,  CSR_MVU_ISTRIDE_1, 32'h0,  1'b0, 1'b1, 32'hCF, 1'b0, 1'b0};
        tbl[5] = '{1'b1, CSR_WRITE, CSR_MVU_COMMAND,   32'h5,  1'b0, 1'b1, 32'h0,  1'b1, 1'b0};
        tbl[6] = '{1'b1, CSR_READ,  CSR_MVU_STATUS,    32'h0,  1'b0, 1'b1, 32'h1,  1'b0, 1'b0};
        tbl[7] = '{1'b1, CSR_MRET,  CSR_MVU_WBASEPTR,  32'h0,  1'b0, 1'b1, 32'h0,  1'b0, 1'b0};
        tbl[8] = '{1'b1, CSR_READ,  12'hF39,           32'h0,  1'b0, 1'b0, 32'h0,  1'b0, 1'b0};

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].v, tbl[i].op, tbl[i].addr, tbl[i].wd, tbl[i].done);
            chk($sformatf("tbl%0d.rvalid", i), CFGW'(bus.csr_rvalid), CFGW'(tbl[i].exp_rv));
            if (tbl[i].exp_rv) chk($sformatf("tbl%0d.rdata", i), CFGW'(bus.csr_rdata), CFGW'(tbl[i].exp_rd));
            chk($sformatf("tbl%0d.start", i), CFGW'(bus.mvu_start), CFGW'(tbl[i].exp_start));
            chk($sformatf("tbl%0d.irq", i), CFGW'(bus.mvu_irq), CFGW'(tbl[i].exp_irq));
        end
        chk("cmd_latched", CFGW'(bus.mvu_cmd), CFGW'(32'h5));

        // Job completes, irq rises, W1C drops it.
        repeat (6) idle_step(1'b0);
        idle_step(1'b1);
        chk("done.irq", CFGW'(bus.mvu_irq), CFGW'(1'b1));
        step(1'b1, CSR_READ, CSR_MVU_STATUS, 32'h0, 1'b0);
        chk("done.status", CFGW'(bus.csr_rdata), CFGW'(32'h2));
        step(1'b1, CSR_WRITE, CSR_MVU_STATUS, 32'h2, 1'b0);
        chk("w1c.irq", CFGW'(bus.mvu_irq), CFGW'(1'b0));

        // Command while busy is dropped and flagged.
        step(1'b1, CSR_WRITE, CSR_MVU_COMMAND, 32'h7, 1'b0);
        chk("cmd7.start", CFGW'(bus.mvu_start), CFGW'(1'b1));
        idle_step(1'b0);
        step(1'b1, CSR_WRITE, CSR_MVU_COMMAND, 32'h9, 1'b0);
        chk("busy.start", CFGW'(bus.mvu_start), CFGW'(1'b0));
        chk("busy.cmd", CFGW'(bus.mvu_cmd), CFGW'(32'h7));
        step(1'b1, CSR_READ, CSR_MVU_STATUS, 32'h0, 1'b0);
        chk("drop.status", CFGW'(bus.csr_rdata), CFGW'(32'h5));
        step(1'b1, CSR_WRITE, CSR_MVU_STATUS, 32'h4, 1'b0);
        step(1'b1, CSR_READ, CSR_MVU_STATUS, 32'h0, 1'b0);
        chk("drop.cleared", CFGW'(bus.csr_rdata), CFGW'(32'h1));

        // Completion and W1C in the same cycle: set wins.
        step(1'b1, CSR_WRITE, CSR_MVU_STATUS, 32'h2, 1'b1);
        chk("race.irq", CFGW'(bus.mvu_irq), CFGW'(1'b1));
        step(1'b1, CSR_READ, CSR_MVU_STATUS, 32'h0, 1'b0);
        chk("race.status", CFGW'(bus.csr_rdata), CFGW'(32'h2));
        step(1'b1, CSR_WRITE, CSR_MVU_STATUS, 32'h2, 1'b0);

        // Completion and command write in the same cycle: command dropped.
        step(1'b1, CSR_WRITE, CSR_MVU_COMMAND, 32'h3, 1'b0);
        idle_step(1'b0);
        step(1'b1, CSR_WRITE, CSR_MVU_COMMAND, 32'h8, 1'b1);
        chk("donecmd.start", CFGW'(bus.mvu_start), CFGW'(1'b0));
        chk("donecmd.cmd", CFGW'(bus.mvu_cmd), CFGW'(32'h3));
        step(1'b1, CSR_READ, CSR_MVU_STATUS, 32'h0, 1'b0);
        chk("donecmd.status", CFGW'(bus.csr_rdata), CFGW'(32'h6));
        step(1'b1, CSR_WRITE, CSR_MVU_STATUS, 32'h6, 1'b0);

        // Config write while busy: shadowed or live depending on build.
        step(1'b1, CSR_WRITE, CSR_MVU_OBASEPTR, 32'h40, 1'b0);
        step(1'b1, CSR_WRITE, CSR_MVU_COMMAND, 32'h1, 1'b0);
        idle_step(1'b0);
        step(1'b1, CSR_WRITE, CSR_MVU_OBASEPTR, 32'h100, 1'b0);
        cfg_view = mvu_cfg_t'(bus.mvu_cfg);
`ifdef PITO_MVU_CSR_SHADOW_EN
        chk("shadow.obaseptr", CFGW'(cfg_view.obaseptr), CFGW'(32'h40));
`else
        chk("live.obaseptr", CFGW'(cfg_view.obaseptr), CFGW'(32'h100));
`endif
        step(1'b1, CSR_READ, CSR_MVU_OBASEPTR, 32'h0, 1'b0);
        chk("obaseptr.read", CFGW'(bus.csr_rdata), CFGW'(32'h100));
        idle_step(1'b1);
        step(1'b1, CSR_WRITE, CSR_MVU_STATUS, 32'h2, 1'b0);

        // Reset mid-job abandons it; the late completion must be ignored.
        step(1'b1, CSR_WRITE, CSR_MVU_COMMAND, 32'h2, 1'b0);
        idle_step(1'b0);
        do_reset(2);
        idle_step(1'b1);
        chk("rstjob.irq", CFGW'(bus.mvu_irq), CFGW'(1'b0));
        step(1'b1, CSR_READ, CSR_MVU_STATUS, 32'h0, 1'b0);
        chk("rstjob.status", CFGW'(bus.csr_rdata), CFGW'(32'h0));

        // Randomized traffic with a responsive MVU plus stray completion pulses.
        cd = 0;
        for (int i = 0; i < 3000; i++) begin
            d  = (cd == 1) || ($urandom_range(0, 40) == 0);
            v  = ($urandom_range(0, 3) != 0);
            op = csr_op_t'($urandom_range(0, 4));
            r  = $urandom_range(0, 9);
            if (r == 0)      addr = CSR_MVU_COMMAND;
            else if (r == 1) addr = CSR_MVU_STATUS;
            else             addr = csr_t'($urandom_range(32'hF1C, 32'hF3C));
            step(v, op, addr, $urandom, d);
            if (cd > 0) cd--;
            if (bus.mvu_start) cd = $urandom_range(1, 12);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
